// File: rtl/ahb_slave_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_slave_arbiter
//
// Purpose:
//   Per-slave-port arbiter for the AHB fabric. One shared slave port (dmem,
//   imem, peri, ...) is handed to one of NUM_MASTER requesters. The highest
//   hprior value wins, and ties are broken round-robin. The grant is registered
//   and only moves at legal AHB boundaries (arbitration points). The arbiter
//   also reports address-phase and data-phase ownership for the fabric muxes.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   Defined   : a beat counter forces an arbitration point after MAX_HOLD
//               active beats of an unlocked owner, so a long SEQ run cannot
//               starve other masters. Locked transfers are never broken.
//   Undefined : there is no beat counter, and an owner keeps the port for
//               any SEQ run.
//
// Parameters:
//   NUM_MASTER  number of requesting masters (2..8)
//   PRIO_W      width of each priority field (larger = higher priority)
//   MAX_HOLD    beat limit per ownership (only with ARB_TIMEOUT_EN)
//
// Ports:
//   hclk          bus clock
//   hreset_n      asynchronous active-low reset
//   hreq          per-master level request
//   hlock         per-master locked-transfer indication
//   hprior        packed priorities, master i at [i*PRIO_W +: PRIO_W]
//   htrans_own    HTRANS of the current address-phase owner (fabric-muxed)
//   hready        HREADY of the shared slave port
//   hgrant        registered one-hot grant, all-zero when idle
//   hmaster       address-phase owner index
//   hmaster_data  data-phase owner index (lags hmaster by one address phase)
//   hmastlock     the current owner's transfer is locked
//   arb_busy      the port is currently owned
// ---------------------------------------------------------------------------
module ahb_slave_arbiter #(
  parameter int NUM_MASTER = 4,
  parameter int PRIO_W     = 2,
  parameter int MAX_HOLD   = 16
) (
  input  logic                           hclk,
  input  logic                           hreset_n,
  input  logic [NUM_MASTER-1:0]          hreq,
  input  logic [NUM_MASTER-1:0]          hlock,
  input  logic [NUM_MASTER*PRIO_W-1:0]   hprior,
  input  logic [1:0]                     htrans_own,
  input  logic                           hready,
  output logic [NUM_MASTER-1:0]          hgrant,
  output logic [$clog2(NUM_MASTER)-1:0]  hmaster,
  output logic [$clog2(NUM_MASTER)-1:0]  hmaster_data,
  output logic                           hmastlock,
  output logic                           arb_busy
);

  localparam int MW = $clog2(NUM_MASTER);

  localparam logic [1:0] HTRANS_SEQ = 2'b11;

  // Reject unsupported configurations at elaboration time.
  if (NUM_MASTER < 2 || NUM_MASTER > 8 || PRIO_W < 1 || MAX_HOLD < 1) begin : g_param_check
    $error("ahb_slave_arbiter: parameter out of supported range");
  end

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [MW-1:0]   rr_ptr;

  logic            ap;
  logic            own_ap;
  logic            timeout_ap;
  logic            grant_load;
  logic            go_idle;
  logic            owner_change;

  logic            win_found;
  logic [MW-1:0]   win_idx;
  logic [PRIO_W-1:0] win_prio;

  logic [PRIO_W-1:0] prio_arr [NUM_MASTER];

  // Unpack the flat priority bus into one field per master.
  for (genvar g = 0; g < NUM_MASTER; g++) begin : g_prio
    assign prio_arr[g] = hprior[g*PRIO_W +: PRIO_W];
  end

  // Winner search. Masters are visited in round-robin order starting at
  // rr_ptr. A later candidate replaces the current best only when its
  // priority is strictly higher, so among equal priorities the first one
  // found from rr_ptr wins.
  always_comb begin
    logic [MW:0]   sum;
    logic [MW-1:0] idx;
    win_found = 1'b0;
    win_idx   = '0;
    win_prio  = '0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_MASTER; k++) begin
      sum = {1'b0, rr_ptr} + (MW+1)'(k);
      if (sum >= (MW+1)'(NUM_MASTER)) begin
        sum = sum - (MW+1)'(NUM_MASTER);
      end
      idx = sum[MW-1:0];
      if (hreq[idx] && (!win_found || (prio_arr[idx] > win_prio))) begin
        win_found = 1'b1;
        win_idx   = idx;
        win_prio  = prio_arr[idx];
      end
    end
  end

  // The owner may be re-arbitrated only when an address phase completes that
  // is not a burst continuation, and never while the owner holds a lock.
  assign own_ap = hready && (htrans_own != HTRANS_SEQ) && !hlock[hmaster];

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] beat_cnt;

  // Counts the active beats (NONSEQ/SEQ with hready) of the current owner.
  // The count saturates at MAX_HOLD-1. It restarts whenever ownership moves
  // to another master or the port goes idle.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      beat_cnt <= '0;
    end else if ((state_q == IDLE) || go_idle || owner_change) begin
      beat_cnt <= '0;
    end else if (hready && htrans_own[1] && (beat_cnt != CNT_MAX)) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // A forced hand-off that may break a SEQ run, but never a locked one.
  assign timeout_ap = hready && !hlock[hmaster] && (beat_cnt == CNT_MAX);
`else
  assign timeout_ap = 1'b0;
`endif

  assign ap = (state_q == IDLE) || own_ap || timeout_ap;

  // Next-state and load decisions.
  always_comb begin
    state_d    = state_q;
    grant_load = 1'b0;
    go_idle    = 1'b0;
    if (ap) begin
      if (win_found) begin
        state_d    = OWN;
        grant_load = 1'b1;
      end else begin
        state_d    = IDLE;
        go_idle    = 1'b1;
      end
    end
  end

  // Leaving IDLE always counts as a new owner, even if the winner matches
  // the stale hmaster value.
  assign owner_change = grant_load && ((state_q == IDLE) || (win_idx != hmaster));

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      hgrant       <= '0;
      hmaster      <= '0;
      hmaster_data <= '0;
      hmastlock    <= 1'b0;
      rr_ptr       <= '0;
    end else begin
      if (grant_load) begin
        hgrant    <= NUM_MASTER'(1) << win_idx;
        hmaster   <= win_idx;
        hmastlock <= hlock[win_idx];
      end else if (go_idle) begin
        // hmaster keeps the last owner so that hmaster_data stays coherent.
        hgrant    <= '0;
        hmastlock <= 1'b0;
      end

      if (owner_change) begin
        rr_ptr <= (win_idx == MW'(NUM_MASTER - 1)) ? '0 : win_idx + 1'b1;
      end

      // The data phase belongs to whoever owned the address phase that
      // just completed.
      if (hready) begin
        hmaster_data <= hmaster;
      end
    end
  end

  assign arb_busy = (state_q == OWN);

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_arbiter
//
// Self-checking bench for ahb_slave_arbiter (NUM_MASTER=4, PRIO_W=2,
// MAX_HOLD=4). It combines a table of directed cycles, hand-written
// lock/timeout/reset sequences, and a randomized run checked against a
// behavioural reference model. It honours ARB_TIMEOUT_EN the same way the
// design does.
// ---------------------------------------------------------------------------
module tb_ahb_slave_arbiter;

  localparam int N    = 4;
  localparam int PW   = 2;
  localparam int MAXH = 4;

  logic           hclk;
  logic           hreset_n;
  logic [N-1:0]   hreq;
  logic [N-1:0]   hlock;
  logic [N*PW-1:0] hprior;
  logic [1:0]     htrans_own;
  logic           hready;
  logic [N-1:0]   hgrant;
  logic [1:0]     hmaster;
  logic [1:0]     hmaster_data;
  logic           hmastlock;
  logic           arb_busy;

  ahb_slave_arbiter #(
    .NUM_MASTER (N),
    .PRIO_W     (PW),
    .MAX_HOLD   (MAXH)
  ) dut (
    .hclk         (hclk),
    .hreset_n     (hreset_n),
    .hreq         (hreq),
    .hlock        (hlock),
    .hprior       (hprior),
    .htrans_own   (htrans_own),
    .hready       (hready),
    .hgrant       (hgrant),
    .hmaster      (hmaster),
    .hmaster_data (hmaster_data),
    .hmastlock    (hmastlock),
    .arb_busy     (arb_busy)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_owned;
  int m_owner;
  int m_rr;
  int m_beats;
  int m_data;
  bit m_lock;

  typedef struct {
    logic [3:0] req;
    logic [3:0] lock;
    logic [7:0] prio;
    logic [1:0] trans;
    logic       rdy;
    logic [3:0] e_grant;
    logic [1:0] e_master;
    logic [1:0] e_data;
    logic       e_lock;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int prio_of(input int i);
    return int'((hprior >> (i*PW)) & 8'h3);
  endfunction

  // Highest priority wins; among equals the first one met walking upward
  // from the round-robin pointer wins. Returns -1 when nobody requests.
  function automatic int pick_winner();
    int best;
    best = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (hreq[i] && (best < 0 || prio_of(i) > prio_of(best))) best = i;
    end
    return best;
  endfunction

  task automatic model_reset();
    m_owned = 0; m_owner = 0; m_rr = 0; m_beats = 0; m_data = 0; m_lock = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit ap;
    bit changed;
    int w;
    int n_beats;
    ap = 0;
    if (!m_owned) ap = 1;
    else if (hready && !hlock[m_owner]) begin
      if (htrans_own != 2'b11) ap = 1;
`ifdef ARB_TIMEOUT_EN
      if (m_beats == MAXH-1) ap = 1;
`endif
    end
    changed = 0;
    n_beats = m_beats;
    if (hready && htrans_own[1] && n_beats < MAXH-1) n_beats++;
    if (hready) m_data = m_owner;
    if (ap) begin
      w = pick_winner();
      if (w >= 0) begin
        changed = !m_owned || (w != m_owner);
        if (changed) m_rr = (w + 1) % N;
        m_owner = w;
        m_owned = 1;
        m_lock  = hlock[w];
      end else begin
        m_owned = 0;
        m_lock  = 0;
      end
    end
    if (!m_owned || changed) n_beats = 0;
    m_beats = n_beats;
  endtask

  task automatic compare_model(input string tag);
    logic [3:0] eg;
    eg = m_owned ? 4'(1 << m_owner) : 4'b0;
    chk({tag, ".hgrant"},       32'(hgrant),       32'(eg));
    chk({tag, ".hmaster"},      32'(hmaster),      32'(m_owner));
    chk({tag, ".hmaster_data"}, 32'(hmaster_data), 32'(m_data));
    chk({tag, ".hmastlock"},    32'(hmastlock),    32'(m_lock));
    chk({tag, ".arb_busy"},     32'(arb_busy),     32'(m_owned));
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge hclk);
    #1;
    compare_model(tag);
  endtask

  task automatic set_in(input logic [3:0] rq, input logic [3:0] lk, input logic [7:0] pr,
                        input logic [1:0] tr, input logic rd);
    hreq = rq; hlock = lk; hprior = pr; htrans_own = tr; hready = rd;
  endtask

  task automatic do_reset();
    hreset_n = 1'b0;
    @(posedge hclk);
    @(posedge hclk);
    #1;
    chk("rst.hgrant",       32'(hgrant),       32'h0);
    chk("rst.hmaster",      32'(hmaster),      32'h0);
    chk("rst.hmaster_data", 32'(hmaster_data), 32'h0);
    chk("rst.hmastlock",    32'(hmastlock),    32'h0);
    chk("rst.arb_busy",     32'(arb_busy),     32'h0);
    hreset_n = 1'b1;
    model_reset();
  endtask

  // Watchdog: the bench must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_in(4'b1111, 4'b0000, 8'h00, 2'b10, 1'b1);
    hreset_n = 1'b0;
    model_reset();

    // Directed table: rotation, priority selection, wait-state freeze.
    //          req      lock     prio   trans  rdy   grant    mst  dat  lck
    tbl.push_back('{4'b1111, 4'b0000, 8'h00, 2'b10, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0});
    tbl.push_back('{4'b1111, 4'b0000, 8'h00, 2'b10, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b0});
    tbl.push_back('{4'b1111, 4'b0000, 8'h00, 2'b10, 1'b1, 4'b0100, 2'd2, 2'd1, 1'b0});
    tbl.push_back('{4'b1111, 4'b0000, 8'h00, 2'b10, 1'b1, 4'b1000, 2'd3, 2'd2, 1'b0});
    tbl.push_back('{4'b1111, 4'b0000, 8'h00, 2'b10, 1'b1, 4'b0001, 2'd0, 2'd3, 1'b0});
    tbl.push_back('{4'b1011, 4'b0000, 8'hC4, 2'b10, 1'b1, 4'b1000, 2'd3, 2'd0, 1'b0});
    tbl.push_back('{4'b1011, 4'b0000, 8'hC4, 2'b10, 1'b1, 4'b1000, 2'd3, 2'd3, 1'b0});
    tbl.push_back('{4'b0011, 4'b0000, 8'hC4, 2'b10, 1'b1, 4'b0010, 2'd1, 2'd3, 1'b0});
    tbl.push_back('{4'b0111, 4'b0000, 8'h34, 2'b11, 1'b0, 4'b0010, 2'd1, 2'd3, 1'b0});
    tbl.push_back('{4'b0111, 4'b0000, 8'h34, 2'b11, 1'b0, 4'b0010, 2'd1, 2'd3, 1'b0});
    tbl.push_back('{4'b0111, 4'b0000, 8'h34, 2'b11, 1'b0, 4'b0010, 2'd1, 2'd3, 1'b0});
    tbl.push_back('{4'b0111, 4'b0000, 8'h34, 2'b11, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0});
    tbl.push_back('{4'b0111, 4'b0000, 8'h34, 2'b00, 1'b1, 4'b0100, 2'd2, 2'd1, 1'b0});
    tbl.push_back('{4'b0111, 4'b0000, 8'h34, 2'b00, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0});

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].req, tbl[i].lock, tbl[i].prio, tbl[i].trans, tbl[i].rdy);
      cycle($sformatf("tbl%0d.model", i));
      chk($sformatf("tbl%0d.hgrant", i),       32'(hgrant),       32'(tbl[i].e_grant));
      chk($sformatf("tbl%0d.hmaster", i),      32'(hmaster),      32'(tbl[i].e_master));
      chk($sformatf("tbl%0d.hmaster_data", i), 32'(hmaster_data), 32'(tbl[i].e_data));
      chk($sformatf("tbl%0d.hmastlock", i),    32'(hmastlock),    32'(tbl[i].e_lock));
    end

    // Locked 8-beat run with competing higher-priority requests.
    do_reset();
    set_in(4'b0001, 4'b0001, 8'hFC, 2'b00, 1'b1);
    cycle("lock.grant");
    chk("lock.first_grant", 32'(hgrant), 32'h1);
    chk("lock.first_lock",  32'(hmastlock), 32'h1);
    for (int b = 0; b < 8; b++) begin
      set_in(4'b1111, 4'b0001, 8'hFC, (b == 0) ? 2'b10 : 2'b11, 1'b1);
      cycle("lock.beat");
      chk($sformatf("lock.beat%0d.hgrant", b),    32'(hgrant),    32'h1);
      chk($sformatf("lock.beat%0d.hmastlock", b), 32'(hmastlock), 32'h1);
    end
    set_in(4'b1111, 4'b0000, 8'hFC, 2'b00, 1'b1);
    cycle("lock.release");
    chk("lock.handoff.hgrant",    32'(hgrant),    32'h2);
    chk("lock.handoff.hmastlock", 32'(hmastlock), 32'h0);

    // Long unlocked SEQ run by master 0 while master 1 requests.
    do_reset();
    set_in(4'b0001, 4'b0000, 8'h00, 2'b00, 1'b1);
    cycle("hold.grant");
    chk("hold.first_grant", 32'(hgrant), 32'h1);
    for (int b = 1; b <= 10; b++) begin
      set_in(4'b0011, 4'b0000, 8'h00, 2'b11, 1'b1);
      cycle("hold.beat");
`ifdef ARB_TIMEOUT_EN
      if (b <= 3) chk($sformatf("hold.beat%0d.hgrant", b), 32'(hgrant), 32'h1);
      else if (b <= 7) chk($sformatf("hold.beat%0d.hgrant", b), 32'(hgrant), 32'h2);
`else
      chk($sformatf("hold.beat%0d.hgrant", b), 32'(hgrant), 32'h1);
`endif
    end

    // Randomized traffic against the reference model, with one
    // asynchronous reset in the middle of the run.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [3:0] lk;
      lk = 4'b0000;
      for (int j = 0; j < N; j++) lk[j] = ($urandom_range(0, 7) == 0);
      set_in(4'($urandom), lk, 8'($urandom),
             2'($urandom), ($urandom_range(0, 3) != 0));
      if (c % 23 == 0) hprior = 8'h00;
      if (c == 200) begin
        #2;
        hreset_n = 1'b0;
        #1;
        chk("async_rst.hgrant",   32'(hgrant),   32'h0);
        chk("async_rst.arb_busy", 32'(arb_busy), 32'h0);
        chk("async_rst.hmaster",  32'(hmaster),  32'h0);
        @(posedge hclk);
        #1;
        hreset_n = 1'b1;
        model_reset();
      end
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
